// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_pkg
//  Description : Shared response codes and FSM state encodings for the
//                AXI memory responder and its storage sub-module.
//  Contents    : RESP_OKAY / RESP_SLVERR response codes,
//                w_state_t (write FSM), r_state_t (read FSM)
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Simple dual-port RAM. One byte-enabled write port and one
//                synchronous read port sharing a single clock. A read and a
//                write to the same word in the same cycle return the old
//                contents (read-first). Contents are never reset.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write word address
//                i_wstrb  - per-byte write enables
//                i_wdata  - write data
//                i_re     - read enable (output register holds when low)
//                i_raddr  - read word address
//                o_rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W/8-1:0]        i_wstrb,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_responder
//  Description : AXI4 slave backed by an on-chip RAM. Services INCR bursts
//                with independent, concurrent read and write FSMs.
//                Optional feature macro: AXI_RESP_ERR_EN
//                  defined   - beats whose word address is >= MEM_DEPTH get
//                              SLVERR, writes are dropped, rdata reads as 0
//                  undefined - addresses wrap modulo MEM_DEPTH
//  Ports       : aclk, aresetn (async active-low)
//                AW: awaddr, awlen, awvalid, awready
//                W : wdata, wstrb, wlast, wvalid, wready
//                B : bresp, bvalid, bready
//                AR: araddr, arlen, arvalid, arready
//                R : rdata, rresp, rlast, rvalid, rready
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int c_NB   = DATA_W / 8;
    localparam int c_OFF  = $clog2(c_NB);
    localparam int c_AW   = $clog2(MEM_DEPTH);
    localparam int c_WA_W = ADDR_W - c_OFF;
    localparam logic [c_WA_W-1:0] c_WONE = {{(c_WA_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- state
    w_state_t             r_wstate;
    logic                 r_awready;
    logic                 r_wready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic [c_WA_W-1:0]    r_wcnt;
    logic [7:0]           r_wlen;
    logic [7:0]           r_wbeat;
    logic                 r_werr;

    r_state_t             r_rstate;
    logic                 r_arready;
    logic                 r_rvalid;
    logic                 r_rlast;
    logic [1:0]           r_rresp;
    logic                 r_rerr;
    logic [c_WA_W-1:0]    r_rcnt;
    logic [7:0]           r_rlen;
    logic [7:0]           r_rbeat;

    // ------------------------------------------------------------ datapath
    // Word counters keep the full address width so the optional range check
    // can see addresses beyond the array; only the low bits index the RAM.
    logic [c_WA_W-1:0]    w_aw_word;
    logic [c_WA_W-1:0]    w_ar_word;
    logic [c_WA_W-1:0]    w_rnext;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_b_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_r_more;
    logic                 w_wbeat_err;
    logic                 w_ar_err;
    logic                 w_rnext_err;
    logic                 w_beat_bad;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [c_AW-1:0]      w_mem_raddr;
    logic [DATA_W-1:0]    w_mem_q;
    logic                 w_unused_lsb;

    assign w_aw_word = awaddr[ADDR_W-1:c_OFF];
    assign w_ar_word = araddr[ADDR_W-1:c_OFF];
    assign w_rnext   = r_rcnt + c_WONE;

    assign w_aw_hs  = awvalid && r_awready;
    assign w_w_hs   = wvalid  && r_wready;
    assign w_b_hs   = r_bvalid && bready;
    assign w_ar_hs  = arvalid && r_arready;
    assign w_r_hs   = r_rvalid && rready;
    assign w_r_more = w_r_hs && (r_rbeat != r_rlen);

    // Byte-lane bits below the word boundary carry no information here.
    assign w_unused_lsb = ^{awaddr[c_OFF-1:0], araddr[c_OFF-1:0]};

`ifdef AXI_RESP_ERR_EN
    assign w_wbeat_err = (r_wcnt    >> c_AW) != '0;
    assign w_ar_err    = (w_ar_word >> c_AW) != '0;
    assign w_rnext_err = (w_rnext   >> c_AW) != '0;
`else
    logic w_unused_hi;
    assign w_wbeat_err = 1'b0;
    assign w_ar_err    = 1'b0;
    assign w_rnext_err = 1'b0;
    assign w_unused_hi = ^{r_wcnt >> c_AW, w_ar_word >> c_AW, w_rnext >> c_AW};
`endif

    // A beat is bad if wlast disagrees with the awlen-derived beat count or
    // (optionally) if it falls outside the array.
    assign w_beat_bad = (wlast != (r_wbeat == r_wlen)) || w_wbeat_err;

    assign w_mem_we = (r_wstate == W_DATA) && w_w_hs && !w_wbeat_err;

    // Fetch beat 0 on the AR handshake and each following beat as the
    // current one is accepted; during a stall the RAM output simply holds.
    assign w_mem_re    = w_ar_hs || w_r_more;
    assign w_mem_raddr = w_ar_hs ? w_ar_word[c_AW-1:0] : w_rnext[c_AW-1:0];

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (aclk),
        .i_we    (w_mem_we),
        .i_waddr (r_wcnt[c_AW-1:0]),
        .i_wstrb (wstrb),
        .i_wdata (wdata),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_q)
    );

    // ------------------------------------------------------------ write FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wcnt    <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wcnt    <= w_aw_word;
                        r_wlen    <= awlen;
                        r_wbeat   <= '0;
                        r_werr    <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wcnt  <= r_wcnt + c_WONE;
                        r_wbeat <= r_wbeat + 8'd1;
                        r_werr  <= r_werr || w_beat_bad;
                        // The burst length comes from awlen, not wlast.
                        if (r_wbeat == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------- read FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rerr    <= 1'b0;
            r_rcnt    <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rcnt    <= w_ar_word;
                        r_rlen    <= arlen;
                        r_rbeat   <= '0;
                        r_rlast   <= (arlen == 8'd0);
                        r_rerr    <= w_ar_err;
                        r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rbeat == r_rlen) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= RESP_OKAY;
                            r_rerr    <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= w_rnext;
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                            r_rerr  <= w_rnext_err;
                            r_rresp <= w_rnext_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rresp   = r_rresp;
    // RAM output register is not reset; gate it so rdata is 0 when idle,
    // in reset, and on out-of-range beats.
    assign rdata   = (r_rvalid && !r_rerr) ? w_mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_responder
//  Description : Directed self-checking bench for axi_mem_responder
//                (DATA_W=32, MEM_DEPTH=256). Expectations follow the
//                AXI_RESP_ERR_EN macro when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];
    logic        rlbuf [16];
    logic [1:0]  rrbuf [16];

    axi_mem_responder #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (256)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ------------------------------------------------------ stimulus tasks
    // All driving happens 1 time unit after a rising edge; outputs are
    // sampled at the same point.
    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len);
        int t = 0;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        while (awready !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
        if (t >= 20) begin checks++; errors++; $display("FAIL aw_timeout awready=%b required=1", awready); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l, output logic ok);
        int t = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (wready !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
        ok = (t < 20);
        if (!ok) begin checks++; errors++; $display("FAIL w_timeout wready=%b required=1", wready); end
        else begin @(posedge aclk); #1; end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
        int t = 0;
        araddr = addr; arlen = len; arvalid = 1'b1;
        while (arready !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
        if (t >= 20) begin checks++; errors++; $display("FAIL ar_timeout arready=%b required=1", arready); end
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                             input int lastbeat, output logic [1:0] resp, output int nbeats,
                             output logic b_early);
        int   t = 0;
        logic ok;
        nbeats = 0;
        aw_phase(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(wbuf[i], strb, (i == lastbeat), ok);
            if (!ok) break;
            nbeats++;
        end
        b_early = bvalid;
        bready = 1'b1;
        while (bvalid !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
        if (t >= 20) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b required=1", bvalid); end
        resp = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            output logic first_valid, output logic ar_after);
        ar_phase(addr, len);
        rready = 1'b1;
        first_valid = rvalid;
        for (int i = 0; i <= int'(len); i++) begin
            int t = 0;
            while (rvalid !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
            if (t >= 20) begin checks++; errors++; $display("FAIL r_timeout rvalid=%b required=1", rvalid); break; end
            rbuf[i] = rdata; rlbuf[i] = rlast; rrbuf[i] = rresp;
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        ar_after = arready;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b required 0", awready); end
        checks++; if (wready  !== 1'b0) begin errors++; $display("FAIL rst_wready got %b required 0", wready); end
        checks++; if (bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b required 0", bvalid); end
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b required 0", arready); end
        checks++; if (rvalid  !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b required 0", rvalid); end
        checks++; if (rlast   !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b required 0", rlast); end
        checks++; if (bresp   !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b required 00", bresp); end
        checks++; if (rresp   !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b required 00", rresp); end
        checks++; if (rdata   !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h required 0", rdata); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rel_awready got %b required 1", awready); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rel_arready got %b required 1", arready); end
        checks++; if (wready  !== 1'b0) begin errors++; $display("FAIL rel_wready got %b required 0", wready); end
    endtask

    task automatic test_burst();
        logic [1:0] resp; int nb; logic be, fv, ara;
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        axi_write(32'h40, 8'd3, 4'hF, 3, resp, nb, be);
        checks++; if (be   !== 1'b1)  begin errors++; $display("FAIL burst_bvalid_next got %b required 1", be); end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL burst_bresp got %b required 00", resp); end
        checks++; if (nb   !== 4)     begin errors++; $display("FAIL burst_wbeats got %0d required 4", nb); end
        axi_read(32'h40, 8'd3, fv, ara);
        checks++; if (fv !== 1'b1) begin errors++; $display("FAIL burst_rvalid_n1 got %b required 1", fv); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbuf[i] !== wbuf[i]) begin errors++; $display("FAIL burst_rdata[%0d] got %h required %h", i, rbuf[i], wbuf[i]); end
            checks++; if (rlbuf[i] !== (i == 3)) begin errors++; $display("FAIL burst_rlast[%0d] got %b required %b", i, rlbuf[i], (i == 3)); end
            checks++; if (rrbuf[i] !== 2'b00) begin errors++; $display("FAIL burst_rresp[%0d] got %b required 00", i, rrbuf[i]); end
        end
        checks++; if (ara !== 1'b1) begin errors++; $display("FAIL burst_arready_after got %b required 1", ara); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; int nb; logic be, fv, ara;
        wbuf[0] = 32'h0000_0000;
        axi_write(32'h80, 8'd0, 4'hF, 0, resp, nb, be);
        wbuf[0] = 32'hAABB_CCDD;
        axi_write(32'h80, 8'd0, 4'b0101, 0, resp, nb, be);
        axi_read(32'h80, 8'd0, fv, ara);
        checks++; if (rbuf[0] !== 32'h00BB_00DD) begin errors++; $display("FAIL strobe_rdata got %h required 00bb00dd", rbuf[0]); end
        checks++; if (rlbuf[0] !== 1'b1) begin errors++; $display("FAIL strobe_rlast got %b required 1", rlbuf[0]); end
    endtask

    task automatic test_rready_stall();
        logic [1:0] resp; int nb; logic be;
        logic [3:0] pat = 4'b1001;   // cycle k uses pat[k%4]: 1,0,0,1
        int hs = 0;
        wbuf[0] = 32'hA0A0_0001; wbuf[1] = 32'hA0A0_0002; wbuf[2] = 32'hA0A0_0003; wbuf[3] = 32'hA0A0_0004;
        axi_write(32'h100, 8'd3, 4'hF, 3, resp, nb, be);
        ar_phase(32'h100, 8'd3);
        for (int k = 0; k < 40 && hs < 4; k++) begin
            rready = pat[k % 4];
            checks++;
            if (rvalid !== 1'b1) begin
                errors++; $display("FAIL stall_rvalid cycle %0d got %b required 1", k, rvalid);
            end else begin
                if (rdata !== wbuf[hs]) begin errors++; $display("FAIL stall_rdata cycle %0d got %h required %h", k, rdata, wbuf[hs]); end
                checks++;
                if (rlast !== (hs == 3)) begin errors++; $display("FAIL stall_rlast cycle %0d got %b required %b", k, rlast, (hs == 3)); end
                if (rready) hs++;
            end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        checks++; if (hs !== 4) begin errors++; $display("FAIL stall_handshakes got %0d required 4", hs); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL stall_rvalid_end got %b required 0", rvalid); end
    endtask

    task automatic test_wlast_mismatch();
        logic [1:0] resp; int nb; logic be;
        wbuf[0] = 32'hC1; wbuf[1] = 32'hC2; wbuf[2] = 32'hC3; wbuf[3] = 32'hC4;
        axi_write(32'hC0, 8'd3, 4'hF, 1, resp, nb, be);
        checks++; if (nb   !== 4)     begin errors++; $display("FAIL wlast_beats got %0d required 4", nb); end
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp got %b required 10", resp); end
    endtask

    task automatic test_addr_range();
        logic [1:0] resp; int nb; logic be, fv, ara;
        wbuf[0] = 32'hCAFE_F00D;
        axi_write(32'h0, 8'd0, 4'hF, 0, resp, nb, be);
        axi_read(32'h400, 8'd0, fv, ara);
`ifdef AXI_RESP_ERR_EN
        checks++; if (rbuf[0]  !== 32'h0) begin errors++; $display("FAIL range_rdata got %h required 0", rbuf[0]); end
        checks++; if (rrbuf[0] !== 2'b10) begin errors++; $display("FAIL range_rresp got %b required 10", rrbuf[0]); end
`else
        checks++; if (rbuf[0]  !== 32'hCAFE_F00D) begin errors++; $display("FAIL range_rdata got %h required cafef00d", rbuf[0]); end
        checks++; if (rrbuf[0] !== 2'b00) begin errors++; $display("FAIL range_rresp got %b required 00", rrbuf[0]); end
`endif
        checks++; if (rlbuf[0] !== 1'b1) begin errors++; $display("FAIL range_rlast got %b required 1", rlbuf[0]); end
    endtask

    task automatic test_read_first();
        logic [1:0] resp; int nb; logic be, fv, ara;
        wbuf[0] = 32'h1234_5678;
        axi_write(32'h300, 8'd0, 4'hF, 0, resp, nb, be);
        aw_phase(32'h300, 8'd0);
        // W and AR handshakes on the same edge, same word.
        wdata = 32'h9ABC_DEF0; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h300; arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
        checks++; if (wready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL rf_ready got wready=%b arready=%b required 1 1", wready, arready);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rf_rvalid got %b required 1", rvalid); end
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL rf_old_data got %h required 12345678", rdata); end
        checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL rf_bvalid got %b required 1", bvalid); end
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        axi_read(32'h300, 8'd0, fv, ara);
        checks++; if (rbuf[0] !== 32'h9ABC_DEF0) begin errors++; $display("FAIL rf_new_data got %h required 9abcdef0", rbuf[0]); end
    endtask

    task automatic test_reset_mid_burst();
        logic ok, fv, ara;
        logic saw_b = 1'b0;
        aw_phase(32'h200, 8'd3);
        w_beat(32'h51, 4'hF, 1'b0, ok);
        w_beat(32'h52, 4'hF, 1'b0, ok);
        aresetn = 1'b0;
        #1;
        checks++; if (wready !== 1'b0 || awready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready got wready=%b awready=%b required 0 0", wready, awready);
        end
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL mid_awready got %b required 1", awready); end
        for (int k = 0; k < 4; k++) begin
            if (bvalid !== 1'b0) saw_b = 1'b1;
            @(posedge aclk); #1;
        end
        checks++; if (saw_b !== 1'b0) begin errors++; $display("FAIL mid_bvalid got %b required 0", saw_b); end
        axi_read(32'h200, 8'd1, fv, ara);
        checks++; if (rbuf[0] !== 32'h51) begin errors++; $display("FAIL mid_beat0 got %h required 51", rbuf[0]); end
        checks++; if (rbuf[1] !== 32'h52) begin errors++; $display("FAIL mid_beat1 got %h required 52", rbuf[1]); end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_burst();
        test_strobe();
        test_rready_stall();
        test_wlast_mismatch();
        test_addr_range();
        test_read_first();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
